// File: rtl/icmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icmp_pkg
// Description : Shared definitions for the ICMP echo responder: ICMP type
//               constants, FSM state encoding and the checksum fold helper.
// Revision    : 1.0 - initial release
// ============================================================================
package icmp_pkg;

  localparam logic [7:0] ICMP_ECHO_REPLY  = 8'd0;
  localparam logic [7:0] ICMP_DST_UNREACH = 8'd3;
  localparam logic [7:0] ICMP_ECHO_REQ    = 8'd8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_TXREQ   = 3'd3,
    ST_TX      = 3'd4,
    ST_DROP    = 3'd5
  } icmp_state_t;

  // One end-around-carry step of the one's-complement sum.
  function automatic logic [31:0] csum_fold(input logic [31:0] value);
    return {16'h0000, value[15:0]} + {16'h0000, value[31:16]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/icmp_payload_buffer.sv
`default_nettype none
// ============================================================================
// Module      : icmp_payload_buffer
// Description : Simple dual-port byte RAM holding one echo payload. The write
//               pointer saturates at MAX_PAYLOAD (never wraps). The read side
//               is show-ahead: rd_data always presents the byte at the read
//               pointer, so a byte is available on the cycle it is needed.
// Ports       : clock, reset_n    clock / async active-low reset
//               clear             empty the buffer (write pointer to 0)
//               wr_en, wr_data    append one byte
//               rd_restart        read pointer back to address 0
//               rd_advance        step to the next byte
//               rd_data           byte at the current read pointer
//               fill              number of bytes written
//               full              fill has reached MAX_PAYLOAD
// Revision    : 1.0 - initial release
// ============================================================================
module icmp_payload_buffer #(
  parameter int MAX_PAYLOAD = 1024,
  parameter int ADDR_W      = 11
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_restart,
  input  logic              rd_advance,
  output logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] fill,
  output logic              full
);

  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_LIMIT = ADDR_W'(MAX_PAYLOAD);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [7:0]        r_rd_data;
  logic              w_write;

  assign full    = (r_wr_ptr == C_LIMIT);
  assign fill    = r_wr_ptr;
  assign rd_data = r_rd_data;
  assign w_write = wr_en && !full;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
    end else if (w_write) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // The read register is loaded from the address the pointer is about to
  // hold, which keeps rd_data aligned with r_rd_ptr at all times.
  always_comb begin
    w_rd_addr = r_rd_ptr;
    if (rd_restart) begin
      w_rd_addr = '0;
    end else if (rd_advance) begin
      w_rd_addr = r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr  <= '0;
      r_rd_data <= 8'h00;
    end else begin
      r_rd_ptr  <= w_rd_addr;
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/icmp_echo_engine.sv
`default_nettype none
// ============================================================================
// Module      : icmp_echo_engine
// Description : ICMP echo responder. Captures one ICMP message from the IP rx
//               demux, buffers the echo payload and replies with a type-0
//               message carrying a recomputed one's-complement checksum.
//               Type-3 messages raise dst_unreachable for one cycle.
//               Optional feature macro ICMP_STATS_EN adds the saturating
//               echo_count / drop_count ports.
// Ports       : clock, reset_n         clock / async active-low reset
//               rx_enable, rx_data     incoming ICMP byte stream
//               remote_mac, remote_ip  sender addresses (first rx cycle)
//               tx_enable              grant from the tx arbiter
//               tx_request             reply waiting for a grant
//               tx_active, tx_data     reply byte stream
//               length                 reply length in bytes
//               destination_mac/_ip    reply addresses
//               dst_unreachable        pulse on a type-3 message
//               unreach_code           code of the last type-3 message
//               echo_count, drop_count (ICMP_STATS_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module icmp_echo_engine #(
  parameter int MAX_PAYLOAD = 1024,
  parameter int ADDR_W      = 11,
  parameter int HEADER_LEN  = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_enable,
  input  logic [7:0]  rx_data,
  input  logic [47:0] remote_mac,
  input  logic [31:0] remote_ip,
  input  logic        tx_enable,
  output logic        tx_request,
  output logic        tx_active,
  output logic [7:0]  tx_data,
  output logic [15:0] length,
  output logic [47:0] destination_mac,
  output logic [31:0] destination_ip,
  output logic        dst_unreachable,
  output logic [7:0]  unreach_code
`ifdef ICMP_STATS_EN
  ,
  output logic [15:0] echo_count,
  output logic [15:0] drop_count
`endif
);

  import icmp_pkg::*;

  icmp_state_t       r_state;
  icmp_state_t       w_next;

  logic              r_rx_prev;
  logic              r_unreach;
  logic [1:0]        r_hdr_idx;
  logic [31:0]       r_sum;
  logic [15:0]       r_csum;
  logic [15:0]       r_length;
  logic [15:0]       r_tx_idx;
  logic [47:0]       r_mac;
  logic [31:0]       r_ip;
  logic              r_dst_unreach;
  logic [7:0]        r_unreach_code;

  logic              w_rx_start;
  logic              w_start_msg;
  logic              w_wr_en;
  logic              w_clear;
  logic              w_rx_done;
  logic              w_unreach_hit;
  logic              w_drop_evt;
  logic              w_echo_done;
  logic              w_grant;
  logic              w_rd_advance;
  logic [7:0]        w_rd_data;
  logic [ADDR_W-1:0] w_fill;
  logic              w_full;
  logic [31:0]       w_fold1;
  logic [31:0]       w_fold2;
  logic              w_fold_unused;

  // Only a rising rx_enable opens a message; a message that began while a
  // reply was busy therefore stays ignored even after the engine is idle.
  assign w_rx_start = rx_enable && !r_rx_prev;

  // Two folds always fit in 16 bits, so the upper half is constant zero.
  assign w_fold1       = csum_fold(r_sum);
  assign w_fold2       = csum_fold(w_fold1);
  assign w_fold_unused = |w_fold2[31:16];

  assign w_rd_advance = (r_state == ST_TX) && (r_tx_idx >= 16'(HEADER_LEN));

  icmp_payload_buffer #(
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .ADDR_W      (ADDR_W)
  ) u_buffer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (w_clear),
    .wr_en      (w_wr_en),
    .wr_data    (rx_data),
    .rd_restart (w_grant),
    .rd_advance (w_rd_advance),
    .rd_data    (w_rd_data),
    .fill       (w_fill),
    .full       (w_full)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_start_msg   = 1'b0;
    w_wr_en       = 1'b0;
    w_clear       = 1'b0;
    w_rx_done     = 1'b0;
    w_unreach_hit = 1'b0;
    w_drop_evt    = 1'b0;
    w_echo_done   = 1'b0;
    w_grant       = 1'b0;
    tx_request    = 1'b0;
    tx_active     = 1'b0;
    tx_data       = 8'h00;

    case (r_state)
      ST_IDLE: begin
        if (w_rx_start) begin
          w_start_msg = 1'b1;
          w_clear     = 1'b1;
          if (rx_data == ICMP_ECHO_REQ || rx_data == ICMP_DST_UNREACH) begin
            w_next = ST_HDR;
          end else begin
            w_next     = ST_DROP;
            w_drop_evt = 1'b1;
          end
        end
      end
      ST_HDR: begin
        // r_hdr_idx: 0 = code byte, 1/2 = received checksum (discarded).
        if (!rx_enable) begin
          w_next     = ST_IDLE;
          w_drop_evt = 1'b1;
        end else if (r_hdr_idx == 2'd0) begin
          if (r_unreach) begin
            w_unreach_hit = 1'b1;
            w_next        = ST_DROP;
          end else if (rx_data != 8'h00) begin
            w_next     = ST_DROP;
            w_drop_evt = 1'b1;
          end
        end else if (r_hdr_idx == 2'd2) begin
          w_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!rx_enable) begin
          w_next    = ST_TXREQ;
          w_rx_done = 1'b1;
        end else if (w_full) begin
          w_next     = ST_DROP;
          w_clear    = 1'b1;
          w_drop_evt = 1'b1;
        end else begin
          w_wr_en = 1'b1;
        end
      end
      ST_TXREQ: begin
        tx_request = 1'b1;
        if (tx_enable) begin
          w_next  = ST_TX;
          w_grant = 1'b1;
        end
      end
      ST_TX: begin
        tx_active = 1'b1;
        case (r_tx_idx)
          16'd0:   tx_data = ICMP_ECHO_REPLY;
          16'd1:   tx_data = 8'h00;
          16'd2:   tx_data = r_csum[15:8];
          16'd3:   tx_data = r_csum[7:0];
          default: tx_data = w_rd_data;
        endcase
        if (r_tx_idx == r_length - 16'd1) begin
          w_next      = ST_IDLE;
          w_echo_done = 1'b1;
        end
      end
      ST_DROP: begin
        if (!rx_enable) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    if ((r_state == ST_TXREQ || r_state == ST_TX) && w_rx_start) begin
      w_drop_evt = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_prev      <= 1'b0;
      r_unreach      <= 1'b0;
      r_hdr_idx      <= 2'd0;
      r_sum          <= 32'd0;
      r_csum         <= 16'd0;
      r_length       <= 16'd0;
      r_tx_idx       <= 16'd0;
      r_mac          <= 48'd0;
      r_ip           <= 32'd0;
      r_dst_unreach  <= 1'b0;
      r_unreach_code <= 8'h00;
    end else begin
      r_rx_prev     <= rx_enable;
      r_dst_unreach <= w_unreach_hit;
      if (w_unreach_hit) begin
        r_unreach_code <= rx_data;
      end
      if (w_start_msg) begin
        r_mac     <= remote_mac;
        r_ip      <= remote_ip;
        r_unreach <= (rx_data == ICMP_DST_UNREACH);
        r_hdr_idx <= 2'd0;
        r_sum     <= 32'd0;
      end
      if (r_state == ST_HDR && rx_enable) begin
        r_hdr_idx <= r_hdr_idx + 2'd1;
      end
      // Even payload bytes are the high half of a 16-bit word.
      if (w_wr_en) begin
        r_sum <= r_sum + (w_fill[0] ? {24'h000000, rx_data} : {16'h0000, rx_data, 8'h00});
      end
      if (w_rx_done) begin
        r_length <= 16'(HEADER_LEN) + 16'(w_fill);
        r_csum   <= ~w_fold2[15:0];
      end
      if (w_grant) begin
        r_tx_idx <= 16'd0;
      end else if (r_state == ST_TX) begin
        r_tx_idx <= r_tx_idx + 16'd1;
      end
    end
  end

  assign length          = r_length;
  assign destination_mac = r_mac;
  assign destination_ip  = r_ip;
  assign dst_unreachable = r_dst_unreach;
  assign unreach_code    = r_unreach_code;

`ifdef ICMP_STATS_EN
  logic [15:0] r_echo_count;
  logic [15:0] r_drop_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_echo_count <= 16'd0;
      r_drop_count <= 16'd0;
    end else begin
      if (w_echo_done && r_echo_count != 16'hFFFF) begin
        r_echo_count <= r_echo_count + 16'd1;
      end
      if (w_drop_evt && r_drop_count != 16'hFFFF) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign echo_count = r_echo_count;
  assign drop_count = r_drop_count;
`else
  logic w_stats_unused;
  assign w_stats_unused = w_echo_done | w_drop_evt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icmp_echo_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_icmp_echo_engine
// Description : Self-checking bench for icmp_echo_engine. A vector table of
//               messages plus hand-written sequences (unreachable, busy
//               ignore, reset during reply) and randomized messages, all
//               checked against a checksum/reply model kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icmp_echo_engine;

  localparam int MAX_PAYLOAD = 1024;

  typedef logic [7:0] bq_t [$];

  typedef struct {
    logic [7:0]  mtype;
    logic [7:0]  code;
    int          plen;
    int          pat;
    bit          exp_reply;
    logic [15:0] exp_len;
    bit          csum_known;
    logic [15:0] exp_csum;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_enable = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [47:0] remote_mac = 48'd0;
  logic [31:0] remote_ip = 32'd0;
  logic        tx_enable = 1'b0;
  logic        tx_request;
  logic        tx_active;
  logic [7:0]  tx_data;
  logic [15:0] length;
  logic [47:0] destination_mac;
  logic [31:0] destination_ip;
  logic        dst_unreachable;
  logic [7:0]  unreach_code;
`ifdef ICMP_STATS_EN
  logic [15:0] echo_count;
  logic [15:0] drop_count;
  int          exp_echo = 0;
  int          exp_drop = 0;
`endif

  int   n_cmp = 0;
  int   n_fail = 0;
  bq_t  got_q;
  int   req_count = 0;
  int   unreach_pulses = 0;
  logic prev_req = 1'b0;

  always #5 clock = ~clock;

  icmp_echo_engine #(
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .ADDR_W      (11),
    .HEADER_LEN  (4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .rx_enable       (rx_enable),
    .rx_data         (rx_data),
    .remote_mac      (remote_mac),
    .remote_ip       (remote_ip),
    .tx_enable       (tx_enable),
    .tx_request      (tx_request),
    .tx_active       (tx_active),
    .tx_data         (tx_data),
    .length          (length),
    .destination_mac (destination_mac),
    .destination_ip  (destination_ip),
    .dst_unreachable (dst_unreachable),
    .unreach_code    (unreach_code)
`ifdef ICMP_STATS_EN
    ,
    .echo_count      (echo_count),
    .drop_count      (drop_count)
`endif
  );

  // Observe the reply side on the inactive edge.
  always @(negedge clock) begin
    if (tx_active) got_q.push_back(tx_data);
    if (tx_request && !prev_req) req_count++;
    prev_req = tx_request;
    if (dst_unreachable) unreach_pulses++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // RFC 1071 style checksum of the reply (header words are zero).
  function automatic logic [15:0] ref_csum(input bq_t p);
    longint unsigned s;
    logic [15:0]     lo;
    s = 0;
    foreach (p[i]) s += (i % 2 == 0) ? longint'(p[i]) * 256 : longint'(p[i]);
    while (s > 65535) s = (s & 65535) + (s >> 16);
    lo = 16'(s);
    return ~lo;
  endfunction

  function automatic bit expect_reply(input logic [7:0] mtype, input logic [7:0] code, input int n);
    return (mtype == 8'h08) && (code == 8'h00) && (n <= MAX_PAYLOAD);
  endfunction

  function automatic bq_t make_payload(input int pat, input int n);
    bq_t        q;
    logic [7:0] abc [3];
    abc = '{8'hAB, 8'hCD, 8'hEF};
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       q.push_back(8'(i));
        1:       q.push_back(abc[i % 3]);
        2:       q.push_back(8'hFF);
        default: q.push_back(8'($urandom));
      endcase
    end
    return q;
  endfunction

  task automatic send_msg(input logic [7:0] mtype, input logic [7:0] code, input bq_t p,
                          input logic [47:0] mac, input logic [31:0] ip);
    @(negedge clock);
    rx_enable  = 1'b1;
    rx_data    = mtype;
    remote_mac = mac;
    remote_ip  = ip;
    @(negedge clock);
    rx_data    = code;
    remote_mac = ~mac;
    remote_ip  = ~ip;
    @(negedge clock);
    rx_data = 8'($urandom);
    @(negedge clock);
    rx_data = 8'($urandom);
    foreach (p[i]) begin
      @(negedge clock);
      rx_data = p[i];
    end
    @(negedge clock);
    rx_enable = 1'b0;
    rx_data   = 8'h00;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (tx_request) begin
        ok = 1'b1;
        tx_enable = 1'b1;
        @(negedge clock);
        tx_enable = 1'b0;
      end
    end
  endtask

  task automatic wait_tx_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clock);
      if (!tx_active) ok = 1'b1;
    end
  endtask

  task automatic check_reply(input string tag, input bq_t p, input logic [15:0] exp_len);
    bq_t         exp;
    logic [15:0] c;
    int          mism;
    c = ref_csum(p);
    exp = {8'h00, 8'h00, c[15:8], c[7:0]};
    foreach (p[i]) exp.push_back(p[i]);
    check({tag, "_length"}, length, exp_len);
    check({tag, "_active_cycles"}, got_q.size(), exp.size());
    mism = 0;
    foreach (exp[i]) if (i >= got_q.size() || got_q[i] !== exp[i]) mism++;
    check({tag, "_bad_bytes"}, mism, 0);
  endtask

  task automatic run_msg(input string tag, input logic [7:0] mtype, input logic [7:0] code,
                         input bq_t p, input bit exp_reply, input logic [15:0] exp_len,
                         input bit csum_known, input logic [15:0] exp_csum);
    bit          ok;
    int          r0;
    logic [47:0] mac;
    logic [31:0] ip;
    mac = {16'($urandom), 32'($urandom)};
    ip  = 32'($urandom);
    r0  = req_count;
    got_q.delete();
    send_msg(mtype, code, p, mac, ip);
    if (exp_reply) begin
      wait_grant(ok);
      check({tag, "_grant"}, ok, 1);
      if (ok) begin
        wait_tx_done(p.size() + 20, ok);
        check({tag, "_tx_done"}, ok, 1);
        check_reply(tag, p, exp_len);
        if (csum_known && got_q.size() >= 4) check({tag, "_csum"}, {got_q[2], got_q[3]}, exp_csum);
        check({tag, "_dmac"}, destination_mac, mac);
        check({tag, "_dip"}, destination_ip, ip);
        check({tag, "_requests"}, req_count - r0, 1);
`ifdef ICMP_STATS_EN
        exp_echo++;
`endif
      end
    end else begin
      repeat (12) @(negedge clock);
      check({tag, "_no_request"}, req_count - r0, 0);
`ifdef ICMP_STATS_EN
      if (mtype != 8'h03) exp_drop++;
`endif
    end
`ifdef ICMP_STATS_EN
    check({tag, "_echo_count"}, echo_count, exp_echo);
    check({tag, "_drop_count"}, drop_count, exp_drop);
`endif
  endtask

  initial begin
    vec_t        vecs [8];
    bq_t         p;
    bit          ok;
    bit          ok2;
    int          r0;
    int          u0;
    int          len;
    logic [7:0]  mt;
    logic [7:0]  cd;
    logic [47:0] mac;
    logic [31:0] ip;

    vecs[0] = '{8'h08, 8'h00, 8,    0, 1'b1, 16'd12,   1'b1, 16'hF3EF};
    vecs[1] = '{8'h08, 8'h00, 3,    1, 1'b1, 16'd7,    1'b1, 16'h6531};
    vecs[2] = '{8'h08, 8'h00, 0,    0, 1'b1, 16'd4,    1'b1, 16'hFFFF};
    vecs[3] = '{8'h08, 8'h00, 1,    2, 1'b1, 16'd5,    1'b1, 16'h00FF};
    vecs[4] = '{8'h08, 8'h05, 4,    3, 1'b0, 16'd0,    1'b0, 16'h0000};
    vecs[5] = '{8'h0D, 8'h00, 6,    3, 1'b0, 16'd0,    1'b0, 16'h0000};
    vecs[6] = '{8'h08, 8'h00, 1024, 0, 1'b1, 16'd1028, 1'b0, 16'h0000};
    vecs[7] = '{8'h08, 8'h00, 1025, 0, 1'b0, 16'd0,    1'b0, 16'h0000};

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_ctrl", {tx_request, tx_active, dst_unreachable, tx_data, unreach_code}, 0);
    check("reset_length", length, 0);
    check("reset_dmac", destination_mac, 0);
    check("reset_dip", destination_ip, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Table-driven messages
    for (int v = 0; v < 8; v++) begin
      p = make_payload(vecs[v].pat, vecs[v].plen);
      run_msg($sformatf("vec%0d", v), vecs[v].mtype, vecs[v].code, p,
              vecs[v].exp_reply, vecs[v].exp_len, vecs[v].csum_known, vecs[v].exp_csum);
    end

    // Destination unreachable, code 3
    u0 = unreach_pulses;
    run_msg("unreach", 8'h03, 8'h03, make_payload(3, 4), 1'b0, 16'd0, 1'b0, 16'h0000);
    check("unreach_pulses", unreach_pulses - u0, 1);
    check("unreach_code", unreach_code, 8'h03);

    // Second echo arriving during the reply is ignored
    p   = make_payload(0, 8);
    mac = 48'h0200_1122_3344;
    ip  = 32'hC0A8_0001;
    r0  = req_count;
    got_q.delete();
    send_msg(8'h08, 8'h00, p, mac, ip);
    wait_grant(ok);
    check("busy_grant", ok, 1);
    fork
      wait_tx_done(60, ok2);
      begin
        repeat (2) @(negedge clock);
        send_msg(8'h08, 8'h00, make_payload(3, 5), ~mac, ~ip);
      end
    join
    check("busy_tx_done", ok2, 1);
    repeat (20) @(negedge clock);
    check_reply("busy", p, 16'd12);
    check("busy_requests", req_count - r0, 1);
    check("busy_dmac", destination_mac, mac);
`ifdef ICMP_STATS_EN
    exp_echo++;
    exp_drop++;
    check("busy_echo_count", echo_count, exp_echo);
    check("busy_drop_count", drop_count, exp_drop);
`endif

    // Reset during reply byte 6
    p = make_payload(0, 8);
    got_q.delete();
    send_msg(8'h08, 8'h00, p, 48'hAA, 32'hBB);
    wait_grant(ok);
    check("rst_grant", ok, 1);
    repeat (6) @(negedge clock);
    check("rst_pre_active", tx_active, 1);
    check("rst_pre_byte", tx_data, p[2]);
    #1 reset_n = 1'b0;
    #1;
    check("rst_ctrl", {tx_request, tx_active, dst_unreachable, tx_data, unreach_code}, 0);
    check("rst_length", length, 0);
    check("rst_dmac", destination_mac, 0);
    check("rst_dip", destination_ip, 0);
`ifdef ICMP_STATS_EN
    check("rst_counts", {echo_count, drop_count}, 0);
    exp_echo = 0;
    exp_drop = 0;
`endif
    @(negedge clock);
    reset_n = 1'b1;
    r0 = req_count;
    repeat (10) @(negedge clock);
    check("rst_no_partial", req_count - r0, 0);
    run_msg("post_rst", 8'h08, 8'h00, make_payload(3, 6), 1'b1, 16'd10, 1'b0, 16'h0000);

    // Randomized messages against the model
    for (int k = 0; k < 12; k++) begin
      mt  = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'h08;
      cd  = ($urandom_range(0, 4) == 0) ? 8'h01 : 8'h00;
      len = $urandom_range(0, 40);
      p   = make_payload(3, len);
      run_msg($sformatf("rnd%0d", k), mt, cd, p, expect_reply(mt, cd, len),
              16'(4 + len), 1'b0, 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
